// File: rtl/frog_pkg.sv
// Shared types and constants for the frog referee: game states, playfield
// geometry, score increments and a saturating score adder.
package frog_pkg;

  typedef enum logic [2:0] {
    PLAY,
    DYING,
    RESPAWN,
    GAME_OVER,
    WIN
  } state_e;

  localparam int HOP_DIS   = 48;
  localparam int D_WIDTH   = 640;
  localparam int D_HEIGHT  = 480;

  localparam int ROW_PTS   = 10;
  localparam int HOME_PTS  = 100;
  localparam int SCORE_MAX = 999;

  function automatic logic [9:0] sat_add(input logic [9:0] a, input int unsigned inc);
    logic [10:0] s;
    s = {1'b0, a} + 11'(inc);
    return (s > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : s[9:0];
  endfunction

endpackage

// File: rtl/frog_referee_box_overlap.sv
// Strict axis-aligned overlap test between two boxes; touching edges do not count.
module box_overlap (
  input  logic [11:0] a_x1_i,
  input  logic [11:0] a_x2_i,
  input  logic [11:0] a_y1_i,
  input  logic [11:0] a_y2_i,
  input  logic [11:0] b_x1_i,
  input  logic [11:0] b_x2_i,
  input  logic [11:0] b_y1_i,
  input  logic [11:0] b_y2_i,
  output logic        hit_o
);

  assign hit_o = (a_x1_i < b_x2_i) && (b_x1_i < a_x2_i) &&
                 (a_y1_i < b_y2_i) && (b_y1_i < a_y2_i);

endmodule

// File: rtl/frog_referee.sv
// Frog game referee: collision/off-screen/home detection, lives, score and end state.
// Optional per-life countdown timer enabled by defining FROG_REFEREE_TIMER_EN.
module frog_referee #(
  parameter int N_OBS          = 4,
  parameter int LIVES          = 3,
  parameter int DEAD_FRAMES    = 2,
  parameter int RESPAWN_FRAMES = 30,
  parameter int START_Y        = 469,
  parameter int HOME_Y         = 37,
  parameter int HOP_DIS        = frog_pkg::HOP_DIS,
  parameter int D_WIDTH        = frog_pkg::D_WIDTH,
  parameter int D_HEIGHT       = frog_pkg::D_HEIGHT
`ifdef FROG_REFEREE_TIMER_EN
  , parameter int TIME_FRAMES  = 1800
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ani_stb,
  input  logic                  i_animate,
  input  logic [11:0]           i_frog_x1,
  input  logic [11:0]           i_frog_x2,
  input  logic [11:0]           i_frog_y1,
  input  logic [11:0]           i_frog_y2,
  input  logic [12*N_OBS-1:0]   i_obs_x1,
  input  logic [12*N_OBS-1:0]   i_obs_x2,
  input  logic [12*N_OBS-1:0]   i_obs_y1,
  input  logic [12*N_OBS-1:0]   i_obs_y2,
  output logic                  o_dead,
  output logic [2:0]            o_lives,
  output logic [9:0]            o_score,
  output logic                  o_game_over,
  output logic                  o_win,
  output logic [10:0]           o_time
);
  import frog_pkg::*;

  localparam int CNT_MAX = (DEAD_FRAMES > RESPAWN_FRAMES) ? DEAD_FRAMES : RESPAWN_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      lives_q;
  logic [9:0]      score_q;
  logic [11:0]     furthest_q;
  logic            dead_q;
  logic            win_q;
  logic            game_over_q;

  logic                step;
  logic [N_OBS-1:0]    hit_vec;
  logic                off_screen;
  logic [12:0]         y_sum;
  logic [11:0]         centre_y;
  logic                at_home;
  logic                new_row;
  logic                timeout;
  logic                die;

  assign step = i_animate & i_ani_stb;

  generate
    for (genvar gi = 0; gi < N_OBS; gi++) begin : g_obs
      box_overlap u_overlap (
        .a_x1_i (i_frog_x1),
        .a_x2_i (i_frog_x2),
        .a_y1_i (i_frog_y1),
        .a_y2_i (i_frog_y2),
        .b_x1_i (i_obs_x1[12*gi +: 12]),
        .b_x2_i (i_obs_x2[12*gi +: 12]),
        .b_y1_i (i_obs_y1[12*gi +: 12]),
        .b_y2_i (i_obs_y2[12*gi +: 12]),
        .hit_o  (hit_vec[gi])
      );
    end
  endgenerate

  // A wrapped left/top edge shows up as x1 > x2 after 12-bit underflow.
  assign off_screen = (i_frog_x1 > i_frog_x2) || (i_frog_y1 > i_frog_y2) ||
                      (i_frog_x2 > 12'(D_WIDTH)) || (i_frog_y2 > 12'(D_HEIGHT));

  assign y_sum    = {1'b0, i_frog_y1} + {1'b0, i_frog_y2};
  assign centre_y = y_sum[12:1];
  assign at_home  = (centre_y <= 12'(HOME_Y));
  assign new_row  = (({1'b0, centre_y} + 13'(HOP_DIS)) <= {1'b0, furthest_q});

`ifdef FROG_REFEREE_TIMER_EN
  logic [10:0] time_q;
  // Timeout fires on the step that brings the counter to zero.
  assign timeout = (time_q <= 11'd1);
  assign o_time  = time_q;
`else
  assign timeout = 1'b0;
  assign o_time  = '0;
`endif

  assign die = (|hit_vec) || off_screen || timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= PLAY;
      cnt_q       <= '0;
      lives_q     <= 3'(LIVES);
      score_q     <= '0;
      furthest_q  <= 12'(START_Y);
      dead_q      <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
`ifdef FROG_REFEREE_TIMER_EN
      time_q      <= 11'(TIME_FRAMES);
`endif
    end else if (step) begin
      case (state_q)
        PLAY: begin
`ifdef FROG_REFEREE_TIMER_EN
          if (time_q != '0) time_q <= time_q - 1'b1;
`endif
          if (die) begin
            if (lives_q != '0) lives_q <= lives_q - 1'b1;
            furthest_q <= 12'(START_Y);
            cnt_q      <= '0;
            dead_q     <= 1'b1;
            state_q    <= DYING;
          end else if (at_home) begin
            score_q <= sat_add(score_q, HOME_PTS);
            win_q   <= 1'b1;
            state_q <= WIN;
          end else if (new_row) begin
            score_q    <= sat_add(score_q, ROW_PTS);
            furthest_q <= furthest_q - 12'(HOP_DIS);
          end
        end
        DYING: begin
          if (cnt_q == CW'(DEAD_FRAMES - 1)) begin
            cnt_q  <= '0;
            dead_q <= 1'b0;
            if (lives_q == '0) begin
              game_over_q <= 1'b1;
              state_q     <= GAME_OVER;
            end else begin
              state_q <= RESPAWN;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESPAWN: begin
          if (cnt_q == CW'(RESPAWN_FRAMES - 1)) begin
            cnt_q   <= '0;
            state_q <= PLAY;
`ifdef FROG_REFEREE_TIMER_EN
            time_q  <= 11'(TIME_FRAMES);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dead      = dead_q;
  assign o_lives     = lives_q;
  assign o_score     = score_q;
  assign o_game_over = game_over_q;
  assign o_win       = win_q;

endmodule

// File: tb/tb_frog_referee.sv
// Self-checking bench for frog_referee: vector table plus hand-written multi-strobe
// sequences, with expected results queued at drive time and popped after the edge.
module tb_frog_referee;

  localparam int N_OBS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                stb;
  logic                anim;
  logic [11:0]         fx1, fx2, fy1, fy2;
  logic [12*N_OBS-1:0] ox1, ox2, oy1, oy2;
  logic                dead;
  logic [2:0]          lives;
  logic [9:0]          score;
  logic                go;
  logic                win;
  logic [10:0]         tm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frog_referee #(
    .N_OBS(N_OBS)
`ifdef FROG_REFEREE_TIMER_EN
    , .TIME_FRAMES(5)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ani_stb   (stb),
    .i_animate   (anim),
    .i_frog_x1   (fx1),
    .i_frog_x2   (fx2),
    .i_frog_y1   (fy1),
    .i_frog_y2   (fy2),
    .i_obs_x1    (ox1),
    .i_obs_x2    (ox2),
    .i_obs_y1    (oy1),
    .i_obs_y2    (oy2),
    .o_dead      (dead),
    .o_lives     (lives),
    .o_score     (score),
    .o_game_over (go),
    .o_win       (win),
    .o_time      (tm)
  );

  typedef struct {
    string       name;
    logic [11:0] fx1, fx2, fy1, fy2;
    logic [11:0] ox1, ox2, oy1, oy2;
    logic        anim;
    logic        dead;
    logic [2:0]  lives;
    logic [9:0]  score;
    logic        win;
    logic        go;
    logic [10:0] tm;
  } vec_t;

  typedef struct {
    string       name;
    logic        dead;
    logic [2:0]  lives;
    logic [9:0]  score;
    logic        win;
    logic        go;
    logic [10:0] tm;
  } exp_t;

  exp_t sb_q[$];

  // ob: 0 = obstacle parked away, 1 = overlapping the frog, 2 = touching its right edge
  function automatic vec_t mk(string nm, int x1, int x2, int cy, int ob, logic an,
                              logic d, int l, int s, logic w, logic g, int t);
    vec_t v;
    v.name = nm;
    v.fx1 = 12'(x1); v.fx2 = 12'(x2);
    v.fy1 = 12'(cy - 11); v.fy2 = 12'(cy + 11);
    v.ox1 = 12'd600; v.ox2 = 12'd620; v.oy1 = 12'd100; v.oy2 = 12'd120;
    if (ob == 1) begin
      v.ox1 = 12'(x1 - 9); v.ox2 = 12'(x2 + 9);
      v.oy1 = 12'(cy - 19); v.oy2 = 12'(cy + 1);
    end else if (ob == 2) begin
      v.ox1 = 12'(x2); v.ox2 = 12'(x2 + 9);
      v.oy1 = 12'(cy - 19); v.oy2 = 12'(cy + 1);
    end
    v.anim = an;
    v.dead = d; v.lives = 3'(l); v.score = 10'(s); v.win = w; v.go = g; v.tm = 11'(t);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty got=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    $display("txn %-12s dead=%0d lives=%0d score=%0d win=%0d go=%0d time=%0d",
             e.name, dead, lives, score, win, go, tm);
    chk({e.name, ".dead"},  32'(dead),  32'(e.dead));
    chk({e.name, ".lives"}, 32'(lives), 32'(e.lives));
    chk({e.name, ".score"}, 32'(score), 32'(e.score));
    chk({e.name, ".win"},   32'(win),   32'(e.win));
    chk({e.name, ".go"},    32'(go),    32'(e.go));
    chk({e.name, ".time"},  32'(tm),    32'(e.tm));
  endtask

  task automatic run_vec(vec_t v);
    exp_t e;
    e.name = v.name; e.dead = v.dead; e.lives = v.lives; e.score = v.score;
    e.win = v.win; e.go = v.go; e.tm = v.tm;
    sb_q.push_back(e);
    @(negedge clk);
    fx1 = v.fx1; fx2 = v.fx2; fy1 = v.fy1; fy2 = v.fy2;
    for (int k = 1; k < N_OBS; k++) begin
      ox1[12*k +: 12] = 12'd600; ox2[12*k +: 12] = 12'd620;
      oy1[12*k +: 12] = 12'd100; oy2[12*k +: 12] = 12'd120;
    end
    ox1[11:0] = v.ox1; ox2[11:0] = v.ox2; oy1[11:0] = v.oy1; oy2[11:0] = v.oy2;
    anim = v.anim;
    stb  = 1'b1;
    @(negedge clk);
    stb  = 1'b0;
    anim = 1'b1;
    compare_pop();
  endtask

  task automatic do_reset(string nm, int t);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    e.name = nm; e.dead = 1'b0; e.lives = 3'd3; e.score = '0;
    e.win = 1'b0; e.go = 1'b0; e.tm = 11'(t);
    sb_q.push_back(e);
    compare_pop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[12];

  initial begin
    rst = 1'b1; stb = 1'b0; anim = 1'b1;
    fx1 = 12'd309; fx2 = 12'd331; fy1 = 12'd458; fy2 = 12'd480;
    ox1 = '0; ox2 = '0; oy1 = '0; oy2 = '0;
    repeat (3) @(negedge clk);

`ifdef FROG_REFEREE_TIMER_EN
    do_reset("reset_t", 5);
    for (int i = 0; i < 4; i++) run_vec(mk("idle", 309, 331, 469, 0, 1, 0, 3, 0, 0, 0, 4 - i));
    run_vec(mk("timeout", 309, 331, 469, 0, 1, 1, 2, 0, 0, 0, 0));
    run_vec(mk("t_dying", 309, 331, 469, 0, 1, 1, 2, 0, 0, 0, 0));
    run_vec(mk("t_dy_end", 309, 331, 469, 0, 1, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 29; i++) run_vec(mk("t_respawn", 309, 331, 469, 0, 1, 0, 2, 0, 0, 0, 0));
    run_vec(mk("t_reload", 309, 331, 469, 0, 1, 0, 2, 0, 0, 0, 5));
    run_vec(mk("t_play", 309, 331, 469, 0, 1, 0, 2, 0, 0, 0, 4));
    do_reset("reset_t2", 5);
`else
    do_reset("reset", 0);

    tbl[0]  = mk("touch",    309, 331, 469, 2, 1, 0, 3, 0,  0, 0, 0);
    tbl[1]  = mk("anim_lo",  309, 331, 469, 1, 0, 0, 3, 0,  0, 0, 0);
    tbl[2]  = mk("row1",     309, 331, 421, 0, 1, 0, 3, 10, 0, 0, 0);
    tbl[3]  = mk("row2",     309, 331, 373, 0, 1, 0, 3, 20, 0, 0, 0);
    tbl[4]  = mk("back",     309, 331, 421, 0, 1, 0, 3, 20, 0, 0, 0);
    tbl[5]  = mk("same",     309, 331, 373, 0, 1, 0, 3, 20, 0, 0, 0);
    tbl[6]  = mk("partial",  309, 331, 326, 0, 1, 0, 3, 20, 0, 0, 0);
    tbl[7]  = mk("row3",     309, 331, 325, 0, 1, 0, 3, 30, 0, 0, 0);
    tbl[8]  = mk("edge_ok",  618, 640, 469, 0, 1, 0, 3, 30, 0, 0, 0);
    tbl[9]  = mk("hit",      309, 331, 469, 1, 1, 1, 2, 30, 0, 0, 0);
    tbl[10] = mk("dying",    309, 331, 469, 0, 1, 1, 2, 30, 0, 0, 0);
    tbl[11] = mk("dying_end",309, 331, 469, 0, 1, 0, 2, 30, 0, 0, 0);
    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Immunity: overlapping and on a new row for all 30 respawn strobes.
    for (int i = 0; i < 30; i++) run_vec(mk("immune", 309, 331, 421, 1, 1, 0, 2, 30, 0, 0, 0));
    run_vec(mk("hit2",     309, 331, 469, 1, 1, 1, 1, 30, 0, 0, 0));
    run_vec(mk("dying2",   309, 331, 469, 0, 1, 1, 1, 30, 0, 0, 0));
    run_vec(mk("dy2_end",  309, 331, 469, 0, 1, 0, 1, 30, 0, 0, 0));
    for (int i = 0; i < 30; i++) run_vec(mk("respawn2", 309, 331, 469, 0, 1, 0, 1, 30, 0, 0, 0));
    run_vec(mk("row_again", 309, 331, 421, 0, 1, 0, 1, 40, 0, 0, 0));
    run_vec(mk("wrap",     4090, 10, 469, 0, 1, 1, 0, 40, 0, 0, 0));
    run_vec(mk("dying3",   309, 331, 469, 0, 1, 1, 0, 40, 0, 0, 0));
    run_vec(mk("game_over", 309, 331, 469, 0, 1, 0, 0, 40, 0, 1, 0));
    for (int i = 0; i < 100; i++) run_vec(mk("go_sticky", 309, 331, 37, (i % 2), 1, 0, 0, 40, 0, 1, 0));

    do_reset("reset2", 0);
    run_vec(mk("home_hit", 309, 331, 37, 1, 1, 1, 2, 0, 0, 0, 0));
    do_reset("rst_dying", 0);
    begin
      vec_t v;
      v = mk("y2_off", 309, 331, 469, 0, 1, 1, 2, 0, 0, 0, 0);
      v.fy1 = 12'd459; v.fy2 = 12'd481;
      run_vec(v);
    end
    run_vec(mk("dying4", 309, 331, 469, 0, 1, 1, 2, 0, 0, 0, 0));
    do_reset("rst_dying2", 0);

    run_vec(mk("home_edge", 309, 331, 38, 0, 1, 0, 3, 10,  0, 0, 0));
    run_vec(mk("home",      309, 331, 37, 0, 1, 0, 3, 110, 1, 0, 0));
    for (int i = 0; i < 5; i++) run_vec(mk("win_sticky", 309, 331, 469, 1, 1, 0, 3, 110, 1, 0, 0));
`endif

    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
